// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] FETCH_PC_RESET = 32'h0000_3000;
  localparam logic [XLEN-1:0] FETCH_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: drives a synchronous instruction memory and presents the
// returned word with its PC to IF/ID, holding it across stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = FETCH_PC_RESET,
  parameter logic [XLEN-1:0] NOP_INST = FETCH_NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Inst_out,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC4_out,
  output logic            valid_out
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] next_pc;

  // Redirect target replaces the sequential address only when the stage advances.
  assign next_pc   = redirect ? redirect_pc : f_pc + PC_STEP;
  assign imem_addr = {f_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      f_pc      <= PC_RESET;
      req_pc    <= '0;
      hold_inst <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          req_pc <= f_pc;
          f_pc   <= f_pc + PC_STEP;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            // Memory moves on next cycle, so park the current word locally.
            hold_inst <= imem_rdata;
            state     <= ST_HOLD;
          end else begin
            req_pc <= f_pc;
            f_pc   <= next_pc;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            req_pc <= f_pc;
            f_pc   <= next_pc;
            state  <= ST_RUN;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    Inst_out  = NOP_INST;
    PC_out    = '0;
    PC4_out   = '0;
    valid_out = 1'b0;
    unique case (state)
      ST_RUN: begin
        Inst_out  = imem_rdata;
        PC_out    = req_pc;
        PC4_out   = req_pc + PC_STEP;
        valid_out = 1'b1;
      end
      ST_HOLD: begin
        Inst_out  = hold_inst;
        PC_out    = req_pc;
        PC4_out   = req_pc + PC_STEP;
        valid_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory returns its own word address; a PC-sequence
// model is compared every cycle, plus directed literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Inst_out;
  logic [31:0] PC_out;
  logic [31:0] PC4_out;
  logic        valid_out;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.PC_RESET(PC_RST), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .Inst_out   (Inst_out),
    .PC_out     (PC_out),
    .PC4_out    (PC4_out),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  // Model of the delivered instruction stream: what PC is on the output and
  // which address is fetched next.
  logic        m_init  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_fetch = '0;

  // Memory word == its address; garbage whenever a stalled slot ignores it.
  always @(posedge clk) begin
    if (stall && m_valid) imem_rdata <= $urandom;
    else                  imem_rdata <= {imem_addr[31:2], 2'b00};
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_fetch <= PC_RST;
    end else if (m_init) begin
      if (!m_valid) begin
        m_valid <= 1'b1;
        m_pc    <= m_fetch;
        m_fetch <= m_fetch + 32'd4;
      end else if (!stall) begin
        m_pc    <= m_fetch;
        m_fetch <= redirect ? redirect_pc : m_fetch + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_valid", 32'(valid_out), 32'(m_valid));
      chk("m_inst",  Inst_out, m_valid ? {m_pc[31:2], 2'b00} : NOP);
      chk("m_pc",    PC_out,   m_valid ? m_pc : 32'd0);
      chk("m_pc4",   PC4_out,  m_valid ? m_pc + 32'd4 : 32'd0);
      chk("m_addr",  imem_addr, {m_fetch[31:2], 2'b00});
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_inst",  Inst_out, NOP);
    chk("rst_pc",    PC_out, 32'd0);

    // Reset release with sequential fetch
    reset = 1'b1;
    #1 chk("c1_valid", 32'(valid_out), 32'd0);
    tick();
    chk("c2_pc", PC_out, 32'h3000);
    chk("c2_inst", Inst_out, 32'h3000);
    tick();
    chk("c3_pc", PC_out, 32'h3004);
    tick();
    chk("c4_pc", PC_out, 32'h3008);

    // Three stalled cycles with changing memory data
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",   PC_out,   32'h3008);
      chk("stall_inst", Inst_out, 32'h3008);
      chk("stall_pc4",  PC4_out,  32'h300C);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", PC_out, 32'h300C);

    // Reset asserted while holding
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    chk("hold_pc", PC_out, 32'h300C);
    reset = 1'b0;
    tick();
    chk("rst_hold_valid", 32'(valid_out), 32'd0);
    chk("rst_hold_inst",  Inst_out, 32'd0);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick();
    chk("restart_pc", PC_out, 32'h3000);
    tick();
    chk("pre_redir_pc", PC_out, 32'h3004);

    // Redirect with delay slot
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    chk("delay_slot_pc", PC_out, 32'h3008);
    redirect = 1'b0;
    tick();
    chk("target_pc",   PC_out,   32'h3100);
    chk("target_inst", Inst_out, 32'h3100);

    // Stall and redirect together: redirect only honoured once unstalled
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3200;
    tick();
    chk("sr_hold_pc", PC_out, 32'h3100);
    stall = 1'b0;
    tick();
    chk("sr_slot_pc", PC_out, 32'h3104);
    redirect = 1'b0;
    tick();
    chk("sr_target_pc", PC_out, 32'h3200);

    // Wrap-around at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_slot_pc", PC_out, 32'h3204);
    redirect = 1'b0;
    tick();
    chk("wrap_pc",  PC_out,  32'hFFFF_FFFC);
    chk("wrap_pc4", PC4_out, 32'h0000_0000);
    tick();
    chk("wrap_next_pc",  PC_out,  32'h0000_0000);
    chk("wrap_next_pc4", PC4_out, 32'h0000_0004);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 4) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      reset       = ($urandom_range(0, 25) != 0);
      tick();
    end
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000, instruction driven while output invalid.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  IF/ID hold request; this unit holds the same instruction while it is high.
REQ-006 SHALL have port redirect  input  1  taken branch/jump resolved in ID.
REQ-007 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-008 SHALL have port imem_addr  output  32  byte address to synchronous instruction memory.
REQ-009 SHALL have port imem_rdata  input  32  memory data, valid one cycle after imem_addr.
REQ-010 SHALL have ports Inst_out, PC_out, PC4_out  output  32 each  IF/ID write data.
REQ-011 SHALL have port valid_out  output  1  Inst_out/PC_out/PC4_out carry a real instruction.

Function
REQ-012 SHALL hold state f_pc (next fetch address), req_pc (address of in-flight response), hold_inst, and an FSM with states EMPTY, RUN, HOLD.
REQ-013 SHALL drive imem_addr = {f_pc[31:2], 2'b00} combinationally in all states.
REQ-014 EMPTY: outputs SHALL be Inst_out=NOP_INST, PC_out=0, PC4_out=0, valid_out=0; next edge: req_pc<=f_pc, f_pc<=f_pc+4, go RUN; stall and redirect ignored.
REQ-015 RUN: outputs SHALL be Inst_out=imem_rdata, PC_out=req_pc, PC4_out=req_pc+4, valid_out=1.
REQ-016 RUN, stall=0: req_pc<=f_pc; f_pc<=redirect ? redirect_pc : f_pc+4; stay RUN.
REQ-017 RUN, stall=1: hold_inst<=imem_rdata; f_pc, req_pc unchanged; go HOLD.
REQ-018 HOLD: outputs SHALL be Inst_out=hold_inst, PC_out=req_pc, PC4_out=req_pc+4, valid_out=1.
REQ-019 HOLD, stall=1: all state unchanged; stay HOLD.
REQ-020 HOLD, stall=0: req_pc<=f_pc; f_pc<=redirect ? redirect_pc : f_pc+4; go RUN.
REQ-021 Instruction delivered in the redirect cycle is the delay slot and SHALL NOT be squashed.
REQ-022 stall and redirect together: stall SHALL win; redirect is dropped; ID re-asserts it.
REQ-023 PC and PC4 arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 = 0.
REQ-024 Outputs SHALL be stable for every cycle stall is high, regardless of imem_rdata.
REQ-025 Latency: an address on imem_addr SHALL appear as PC_out exactly one cycle later when unstalled.

Reset
REQ-026 On a clk edge with reset=0: f_pc<=PC_RESET, req_pc<=0, hold_inst<=0, state<=EMPTY.
REQ-027 Reset SHALL override stall and redirect and discard any held instruction mid-operation.
REQ-028 While reset=0, outputs SHALL show EMPTY values after the first edge.

Structure
REQ-029 Shared package SHALL hold PC_RESET, NOP_INST, and the FSM state encoding (2 bits: EMPTY=0, RUN=1, HOLD=2).
REQ-030 Single module; no sub-module required; next-PC selection is an inline mux.

Verification
REQ-031 Reset release, stall=0, memory returns word = address: cycle 1 valid_out=0; cycle 2 PC_out=0x3000, Inst_out=0x3000; cycle 3 PC_out=0x3004.
REQ-032 Stall high for 3 cycles while PC_out=0x3008, memory data changes every cycle: Inst_out, PC_out, PC4_out=0x300C frozen; the next PC_out after release is 0x300C.
REQ-033 redirect=1, redirect_pc=0x3100 while PC_out=0x3004: next PC_out=0x3008 (delay slot), then 0x3100.
REQ-034 stall=1 and redirect=1 in the same cycle, then stall=0 with redirect=1, redirect_pc=0x3200: target taken only on the unstalled cycle; no PC is skipped or duplicated.
REQ-035 reset=0 asserted in HOLD: next edge valid_out=0, Inst_out=0; after release, fetch restarts at 0x3000.
REQ-036 redirect_pc=0xFFFF_FFFC: PC4_out=0, next PC_out=0.
